// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its two requesters and the memory.
// The arbiter binds the slave modport; the requester/memory side binds master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req and holds *_we/*_addr/*_wdata stable until
  // the cycle its *_gnt is high; that cycle the access is taken. A new request may
  // follow in the very next cycle. *_rvalid pulses once, 1 cycle after a read's gnt.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;
  logic              cpu_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read data memory between
// the CPU and the host loader, with a host lock mode (SHARED -> DRAIN -> LOCKED).
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    o_fsm_state
);

  typedef enum logic [1:0] {
    ST_SHARED = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_dbg;
  logic              r_rd_valid;
  logic              r_rd_dbg;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_cpu_ok;
  logic              w_dbg_ok;
  logic              w_cpu_gnt;
  logic              w_dbg_gnt;
  logic              w_gnt_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_cpu_rvalid;
  logic              w_dbg_rvalid;

  // Reset masks every request so nothing is granted or strobed in a reset cycle.
  assign w_cpu_ok  = bus.cpu_req & (r_state == ST_SHARED) & ~rst;
  assign w_dbg_ok  = bus.dbg_req & ~rst;
  assign w_cpu_gnt = w_cpu_ok & (~w_dbg_ok | r_last_dbg);
  assign w_dbg_gnt = w_dbg_ok & ~w_cpu_gnt;
  assign w_gnt_any = w_cpu_gnt | w_dbg_gnt;

  assign w_cpu_rvalid = ~rst & r_rd_valid & ~r_rd_dbg;
  assign w_dbg_rvalid = ~rst & r_rd_valid & r_rd_dbg;

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_cpu_gnt) begin
      w_we    = bus.cpu_we;
      w_addr  = bus.cpu_addr;
      w_wdata = bus.cpu_wdata;
    end else if (w_dbg_gnt) begin
      w_we    = bus.dbg_we;
      w_addr  = bus.dbg_addr;
      w_wdata = bus.dbg_wdata;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SHARED: if (bus.dbg_lock) w_state_next = ST_DRAIN;
      // CPU is never granted in DRAIN, so the only CPU read that can still be
      // outstanding returns during this cycle; LOCKED is safe on the next edge.
      ST_DRAIN:  w_state_next = bus.dbg_lock ? ST_LOCKED : ST_SHARED;
      ST_LOCKED: if (!bus.dbg_lock) w_state_next = ST_SHARED;
      default:   w_state_next = ST_SHARED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SHARED;
      r_last_dbg  <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_dbg    <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= w_gnt_any & ~w_we;
      r_rd_dbg   <= w_dbg_gnt;
      if (w_gnt_any) r_last_dbg <= w_dbg_gnt;
      if (w_cpu_rvalid) r_cpu_rdata <= bus.mem_rdata;
      if (w_dbg_rvalid) r_dbg_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.cpu_gnt    = w_cpu_gnt;
    bus.dbg_gnt    = w_dbg_gnt;
    bus.mem_en     = w_gnt_any;
    bus.mem_we     = w_we;
    bus.mem_addr   = w_addr;
    bus.mem_wdata  = w_wdata;
    bus.cpu_rvalid = w_cpu_rvalid;
    bus.dbg_rvalid = w_dbg_rvalid;
    bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
    bus.dbg_rdata  = w_dbg_rvalid ? bus.mem_rdata : r_dbg_rdata;
    bus.cpu_stall  = ~rst & ((bus.cpu_req & ~w_cpu_gnt) | (r_state != ST_SHARED));
    if (rst) begin
      bus.cpu_rdata = '0;
      bus.dbg_rdata = '0;
    end
  end

  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a request-level model with its own shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] env_mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW:0]   exp_q [$];

  bit            m_last_dbg;
  int            m_lock_run;
  logic [DW-1:0] m_cpu_hold, m_dbg_hold;
  bit            m_gnt_cpu, m_gnt_dbg;

  logic          c_cpu_gnt, c_dbg_gnt, c_cpu_rvalid, c_dbg_rvalid, c_stall, c_en, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_cpu_rdata, c_dbg_rdata;
  logic [1:0]    c_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_dbg = 1'b1;
    m_lock_run = 0;
    exp_q.delete();
    m_cpu_hold = '0;
    m_dbg_hold = '0;
    m_gnt_cpu  = 1'b0;
    m_gnt_dbg  = 1'b0;
  endtask

  task automatic set_cpu(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = AW'(addr); bus.cpu_wdata = wd;
  endtask

  task automatic set_dbg(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = AW'(addr); bus.dbg_wdata = wd;
  endtask

  // One clock: check at negedge, advance the model, then let the memory act on the edge.
  task automatic step();
    logic [DW:0]   e;
    bit            ev_cpu, ev_dbg, cpu_ok, dbg_ok, wc, wd, en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    exp_state;
    @(negedge clk);
    c_cpu_gnt = bus.cpu_gnt;       c_dbg_gnt = bus.dbg_gnt;
    c_cpu_rvalid = bus.cpu_rvalid; c_dbg_rvalid = bus.dbg_rvalid;
    c_cpu_rdata = bus.cpu_rdata;   c_dbg_rdata = bus.dbg_rdata;
    c_stall = bus.cpu_stall;       c_en = bus.mem_en;  c_we = bus.mem_we;
    c_addr = bus.mem_addr;         c_wdata = bus.mem_wdata;
    c_state = fsm_state;
    if (rst) begin
      chk("rst_ctrl", {c_cpu_gnt, c_dbg_gnt, c_cpu_rvalid, c_dbg_rvalid, c_stall, c_en, c_we}, 0);
      chk("rst_bus", {c_addr, c_wdata}, 0);
      chk("rst_rdata", {c_cpu_rdata, c_dbg_rdata}, 0);
      model_reset();
    end else begin
      ev_cpu = 1'b0; ev_dbg = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[DW]) begin ev_dbg = 1'b1; m_dbg_hold = e[DW-1:0]; end
        else begin ev_cpu = 1'b1; m_cpu_hold = e[DW-1:0]; end
      end
      chk("cpu_rvalid", c_cpu_rvalid, ev_cpu);
      chk("dbg_rvalid", c_dbg_rvalid, ev_dbg);
      chk("cpu_rdata", c_cpu_rdata, m_cpu_hold);
      chk("dbg_rdata", c_dbg_rdata, m_dbg_hold);
      // CPU may be served only when the lock was low on the previous cycle.
      cpu_ok = bus.cpu_req && (m_lock_run == 0);
      dbg_ok = bus.dbg_req;
      wc = cpu_ok && (!dbg_ok || m_last_dbg);
      wd = dbg_ok && !wc;
      en = wc || wd;
      we = wc ? bus.cpu_we : (wd ? bus.dbg_we : 1'b0);
      addr = wc ? bus.cpu_addr : (wd ? bus.dbg_addr : '0);
      wdata = wc ? bus.cpu_wdata : (wd ? bus.dbg_wdata : '0);
      exp_state = (m_lock_run == 0) ? 2'd0 : ((m_lock_run == 1) ? 2'd1 : 2'd2);
      chk("cpu_gnt", c_cpu_gnt, wc);
      chk("dbg_gnt", c_dbg_gnt, wd);
      chk("cpu_stall", c_stall, (bus.cpu_req && !wc) || (m_lock_run != 0));
      chk("fsm_state", c_state, exp_state);
      chk("mem_strobe", {c_en, c_we}, {en, we});
      chk("mem_addr", c_addr, addr);
      chk("mem_wdata", c_wdata, wdata);
      if (en) begin
        if (we) ref_mem[addr] = wdata;
        else exp_q.push_back({wd, ref_mem[addr]});
        m_last_dbg = wd;
      end
      m_lock_run = bus.dbg_lock ? ((m_lock_run < 2) ? m_lock_run + 1 : 2) : 0;
      m_gnt_cpu = wc;
      m_gnt_dbg = wd;
    end
    @(posedge clk);
    #1;
    if (c_en && !c_we) bus.mem_rdata = env_mem[c_addr];
    else if (c_en && c_we) env_mem[c_addr] = c_wdata;
  endtask

  task automatic do_reset();
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    bus.dbg_lock = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    bus.mem_rdata = '0;
    model_reset();
    do_reset();
    do_reset();

    // CPU write then read of address 3
    set_cpu(1, 1, 3, 32'h0000_03E8); step(); chk("t1_wr_gnt", c_cpu_gnt, 1);
    set_cpu(1, 0, 3, 0);             step(); chk("t1_rd_gnt", c_cpu_gnt, 1);
    set_cpu(0, 0, 0, 0);             step();
    chk("t1_rvalid", c_cpu_rvalid, 1);
    chk("t1_rdata", c_cpu_rdata, 32'h0000_03E8);

    // Both read every cycle: CPU first, then strict alternation
    do_reset();
    set_cpu(1, 0, 7, 0);
    set_dbg(1, 0, 8, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_cpu_gnt", c_cpu_gnt, (i % 2) == 0);
      chk("t2_dbg_gnt", c_dbg_gnt, (i % 2) == 1);
      if (i == 1) chk("t2_cpu_rdata", c_cpu_rdata, 32'hA000_0007);
      if (i == 2) chk("t2_dbg_rdata", c_dbg_rdata, 32'hA000_0008);
    end
    set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); step();

    // Host alone for four cycles
    set_dbg(1, 0, 9, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_dbg_gnt", c_dbg_gnt, 1);
      chk("t3_cpu_rvalid", c_cpu_rvalid, 0);
    end
    set_dbg(0, 0, 0, 0); step();

    // Lock raised while a CPU read is granted
    do_reset();
    set_cpu(1, 0, 3, 0); bus.dbg_lock = 1'b1;
    step(); chk("t4_cpu_gnt", c_cpu_gnt, 1);
    set_dbg(1, 1, 20, 32'h0000_1111);
    step();
    chk("t4_drain", c_state, 1);
    chk("t4_rvalid", c_cpu_rvalid, 1);
    chk("t4_rdata", c_cpu_rdata, 32'h0000_03E8);
    chk("t4_stall_drain", {c_cpu_gnt, c_stall, c_dbg_gnt}, 3'b011);
    step();
    chk("t4_locked", c_state, 2);
    chk("t4_stall_locked", {c_cpu_gnt, c_stall, c_dbg_gnt}, 3'b011);
    bus.dbg_lock = 1'b0;
    step();
    chk("t4_unlock_cycle", {c_cpu_gnt, c_stall, c_dbg_gnt}, 3'b011);
    step();
    chk("t4_shared", c_state, 0);
    chk("t4_cpu_back", {c_cpu_gnt, c_stall}, 2'b10);
    set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); step();

    // Reset right after a granted read
    do_reset();
    set_cpu(1, 0, 4, 0); step(); chk("t5_cpu_gnt", c_cpu_gnt, 1);
    set_dbg(1, 0, 4, 0); rst = 1'b1; step();
    chk("t5_rst_quiet", {c_cpu_rvalid, c_cpu_gnt, c_dbg_gnt, c_en}, 0);
    rst = 1'b0; step();
    chk("t5_cpu_first", {c_cpu_gnt, c_dbg_gnt}, 2'b10);
    set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); step(); step();

    // Same-address write/read: CPU wins after reset (old data), DBG wins after a CPU grant (new data)
    do_reset();
    set_cpu(1, 0, 5, 0); set_dbg(1, 1, 5, 32'hDEAD_BEEF);
    step(); chk("t6a_cpu_gnt", c_cpu_gnt, 1);
    set_cpu(0, 0, 0, 0);
    step(); chk("t6a_dbg_gnt", c_dbg_gnt, 1);
    chk("t6a_old", {c_cpu_rvalid, c_cpu_rdata}, {1'b1, 32'hA000_0005});
    set_dbg(0, 0, 0, 0); set_cpu(1, 1, 9, 5); step();
    set_cpu(1, 0, 6, 0); set_dbg(1, 1, 6, 32'hCAFE_F00D);
    step(); chk("t6b_dbg_gnt", c_dbg_gnt, 1);
    set_dbg(0, 0, 0, 0); step(); chk("t6b_cpu_gnt", c_cpu_gnt, 1);
    set_cpu(0, 0, 0, 0); step();
    chk("t6b_new", {c_cpu_rvalid, c_cpu_rdata}, {1'b1, 32'hCAFE_F00D});

    // Random traffic with lock toggling and occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!bus.cpu_req || m_gnt_cpu)
        set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
      if (!bus.dbg_req || m_gnt_dbg)
        set_dbg($urandom_range(0, 99) < 50, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 99) < 5) bus.dbg_lock = !bus.dbg_lock;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); bus.dbg_lock = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
